// File: rtl/aes_key_schedule_ctrl.sv
// Sequencer for the masked 32-bit AES-128 key datapath.
// Walks round 0 then ten S-box-fed update rounds, one column per cycle.
module aes_key_schedule_ctrl #(
  parameter int SB_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       sb_gnt,
  output logic       init,
  output logic       enable,
  output logic       loop,
  output logic       add_from_sb,
  output logic       rcon_rst,
  output logic       rcon_update,
  output logic       sb_req,
  output logic       key_col_valid,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND0,
    S_SB_REQ,
    S_SB_WAIT,
    S_UPD,
    S_DONE
  } state_e;

  // SB_WAIT spans SB_LAT-1 cycles so UPD col 0 meets the S-box output
  localparam int WAIT_I = (SB_LAT > 1) ? SB_LAT - 2 : 0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_I);

  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] round_q, round_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      wait_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    wait_d  = wait_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        round_d = 4'd0;
        col_d   = 2'd0;
        state_d = S_ROUND0;
      end
      S_ROUND0: begin
        if (!hold) begin
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            round_d = 4'd1;
            state_d = S_SB_REQ;
          end
        end
      end
      S_SB_REQ: begin
        if (!hold && sb_gnt) begin
          if (SB_LAT == 1) begin
            col_d   = 2'd0;
            state_d = S_UPD;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = S_SB_WAIT;
          end
        end
      end
      S_SB_WAIT: begin
        if (wait_q == 4'd0) begin
          col_d   = 2'd0;
          state_d = S_UPD;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_UPD: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          if (round_q == 4'd10) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_SB_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    init          = 1'b0;
    enable        = 1'b0;
    loop          = 1'b0;
    add_from_sb   = 1'b0;
    rcon_rst      = 1'b0;
    rcon_update   = 1'b0;
    sb_req        = 1'b0;
    key_col_valid = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        init     = 1'b1;
        enable   = 1'b1;
        rcon_rst = 1'b1;
      end
      S_ROUND0: begin
        loop          = 1'b1;
        enable        = !hold;
        key_col_valid = !hold;
      end
      S_SB_REQ: begin
        sb_req = !hold;
      end
      S_UPD: begin
        enable        = 1'b1;
        key_col_valid = 1'b1;
        add_from_sb   = (col_q == 2'd0);
        rcon_update   = (col_q == 2'd3);
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign round_idx = round_q;
  assign busy      = (state_q != S_IDLE);

endmodule
